// File: rtl/temp_disp_pkg.sv
// Shared constants for the temperature readout: FSM encoding and BCD digit geometry.
package temp_disp_pkg;
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_CONVERT    = 2'd1;
    localparam logic [1:0] ST_WAIT_FRAME = 2'd2;
    localparam logic [1:0] ST_COMMIT     = 2'd3;

    localparam int BCD_W      = 4;
    localparam int BCD_DIGITS = 3;
    localparam int BCD_TOT_W  = BCD_W * BCD_DIGITS;

    localparam logic [BCD_W-1:0] BLANK_CODE_DEF = 4'hA;
endpackage

// File: rtl/temp_display_ctrl_bin2bcd_seq.sv
// Iterative double-dabble engine: one add-3/shift step per cycle, TEMP_W steps per conversion.
module bin2bcd_seq
    import temp_disp_pkg::*;
#(
    parameter int TEMP_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [TEMP_W-1:0]    bin_in,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_TOT_W-1:0] bcd
);
    localparam int CNT_W = $clog2(TEMP_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(TEMP_W - 1);

    logic [TEMP_W-1:0]    bin_q, bin_d;
    logic [BCD_TOT_W-1:0] bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5)
                bcd_adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
        end

        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start && !busy_q) begin
            bin_d  = bin_in;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {bcd_adj[BCD_TOT_W-2:0], bin_q[TEMP_W-1]};
            bin_d = {bin_q[TEMP_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // done flags the cycle whose edge performs the final shift
    assign done = busy_q && (cnt_q == LAST_STEP);
    assign busy = busy_q;
    assign bcd  = bcd_q;
endmodule

// File: rtl/temp_display_ctrl.sv
// Temperature readout sequencer: clamp, BCD conversion, commit on frame tick.
// Optional leading-zero blanking when TEMP_DISP_LZB_EN is defined.
module temp_display_ctrl
    import temp_disp_pkg::*;
#(
    parameter int               TEMP_W     = 10,
    parameter int               MAX_VAL    = 999,
    parameter logic [BCD_W-1:0] BLANK_CODE = BLANK_CODE_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic              temp_valid,
    output logic              temp_ready,
    input  logic              frame_tick,
    output logic [3:0]        temp_value_100,
    output logic [3:0]        temp_value_10,
    output logic [3:0]        temp_value_1,
    output logic              overrange,
    output logic              update_done
);
    localparam logic [TEMP_W-1:0] MAX_V = TEMP_W'(MAX_VAL);

    logic [1:0]           state_q, state_d;
    logic                 ovr_pend_q, ovr_pend_d;
    logic [BCD_W-1:0]     d100_q, d100_d, d10_q, d10_d, d1_q, d1_d;
    logic                 overrange_q, overrange_d;
    logic                 update_done_q, update_done_d;

    logic                 temp_over;
    logic [TEMP_W-1:0]    temp_clamped;
    logic                 eng_start, eng_busy, eng_done;
    logic [BCD_TOT_W-1:0] eng_bcd;
    logic [BCD_W-1:0]     raw_100, raw_10, raw_1;
    logic                 blank_100, blank_10;

    assign temp_over    = temp_in > MAX_V;
    assign temp_clamped = temp_over ? MAX_V : temp_in;
    assign temp_ready   = (state_q == ST_IDLE);
    assign eng_start    = temp_ready && temp_valid && !eng_busy;

    bin2bcd_seq #(.TEMP_W(TEMP_W)) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .bin_in (temp_clamped),
        .busy   (eng_busy),
        .done   (eng_done),
        .bcd    (eng_bcd)
    );

    assign raw_100 = eng_bcd[3*BCD_W-1:2*BCD_W];
    assign raw_10  = eng_bcd[2*BCD_W-1:BCD_W];
    assign raw_1   = eng_bcd[BCD_W-1:0];

`ifdef TEMP_DISP_LZB_EN
    assign blank_100 = (raw_100 == '0);
    assign blank_10  = (raw_100 == '0) && (raw_10 == '0);
`else
    assign blank_100 = 1'b0;
    assign blank_10  = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        ovr_pend_d    = ovr_pend_q;
        d100_d        = d100_q;
        d10_d         = d10_q;
        d1_d          = d1_q;
        overrange_d   = overrange_q;
        update_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (eng_start) begin
                    ovr_pend_d = temp_over;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (eng_done)
                    state_d = ST_WAIT_FRAME;
            end
            // frame ticks outside this state are dropped, never queued
            ST_WAIT_FRAME: begin
                if (frame_tick)
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                d100_d        = blank_100 ? BLANK_CODE : raw_100;
                d10_d         = blank_10  ? BLANK_CODE : raw_10;
                d1_d          = raw_1;
                overrange_d   = ovr_pend_q;
                update_done_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ovr_pend_q    <= 1'b0;
            d100_q        <= '0;
            d10_q         <= '0;
            d1_q          <= '0;
            overrange_q   <= 1'b0;
            update_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ovr_pend_q    <= ovr_pend_d;
            d100_q        <= d100_d;
            d10_q         <= d10_d;
            d1_q          <= d1_d;
            overrange_q   <= overrange_d;
            update_done_q <= update_done_d;
        end
    end

    assign temp_value_100 = d100_q;
    assign temp_value_10  = d10_q;
    assign temp_value_1   = d1_q;
    assign overrange      = overrange_q;
    assign update_done    = update_done_q;
endmodule

// File: tb/tb_temp_display_ctrl.sv
// Scoreboard bench for temp_display_ctrl: decimal reference model, expected commits queued.
module tb_temp_display_ctrl;
    localparam int TEMP_W = 10;

    typedef struct {
        int h;
        int t;
        int o;
        int ovr;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [TEMP_W-1:0] temp_in = '0;
    logic              temp_valid = 1'b0;
    logic              temp_ready;
    logic              frame_tick = 1'b0;
    logic [3:0]        temp_value_100, temp_value_10, temp_value_1;
    logic              overrange, update_done;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic rst_s = 1'b1;
    exp_t q[$];
    exp_t shown;

    temp_display_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .temp_in        (temp_in),
        .temp_valid     (temp_valid),
        .temp_ready     (temp_ready),
        .frame_tick     (frame_tick),
        .temp_value_100 (temp_value_100),
        .temp_value_10  (temp_value_10),
        .temp_value_1   (temp_value_1),
        .overrange      (overrange),
        .update_done    (update_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_s <= reset;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int t, input int commit_cyc);
        exp_t e;
        int   v;
        v     = (t > 999) ? 999 : t;
        e.h   = v / 100;
        e.t   = (v / 10) % 10;
        e.o   = v % 10;
        e.ovr = (t > 999) ? 1 : 0;
        e.cyc = commit_cyc;
`ifdef TEMP_DISP_LZB_EN
        if (e.h == 0) begin
            e.h = 10;
            if (e.t == 0) e.t = 10;
        end
`endif
        return e;
    endfunction

    // Monitor: outputs must hold except on update_done, which must match the queue head.
    initial begin
        shown = '{0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (rst_s) begin
                shown = '{0, 0, 0, 0, 0};
                chk("reset_digits", {temp_value_100, temp_value_10, temp_value_1}, 0);
                chk("reset_overrange", overrange, 0);
                chk("reset_update_done", update_done, 0);
            end else if (update_done) begin
                if (q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("commit_cycle", cyc, e.cyc);
                    chk("digit_100", temp_value_100, e.h);
                    chk("digit_10", temp_value_10, e.t);
                    chk("digit_1", temp_value_1, e.o);
                    chk("overrange", overrange, e.ovr);
                    shown = e;
                end
            end else begin
                chk("hold", {temp_value_100, temp_value_10, temp_value_1, overrange},
                    {shown.h[3:0], shown.t[3:0], shown.o[3:0], shown.ovr[0]});
            end
        end
    end

    // Issue one sample; tick lands k cycles into WAIT_FRAME.
    task automatic send(input int v, input int k, input bit hold, input bit storm);
        int n;
        int a;
        n = 0;
        while (!temp_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!temp_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        temp_in    = TEMP_W'(v);
        temp_valid = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        q.push_back(model(v, a + TEMP_W + 2 + k));
        if (!hold) temp_valid = 1'b0;
        if (storm) frame_tick = 1'b1;
        repeat (TEMP_W + k) begin
            chk("ready_busy", temp_ready, 0);
            if (hold) temp_in = TEMP_W'($urandom_range(0, 1023));
            @(posedge clk); #1;
        end
        temp_valid = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // idle: ready high, outputs zero, no commit
        repeat (20) begin
            @(posedge clk); #1;
            chk("idle_ready", temp_ready, 1);
        end

        send(72, 5, 1'b0, 1'b0);
        send(1023, 0, 1'b0, 1'b0);
        send(999, 2, 1'b0, 1'b0);
        send(5, 1, 1'b0, 1'b0);
        send(0, 0, 1'b0, 1'b0);
        send(456, 0, 1'b0, 1'b1);
        send(818, 0, 1'b1, 1'b0);

        // reset mid-conversion discards the sample
        temp_in    = TEMP_W'(345);
        temp_valid = 1'b1;
        @(posedge clk); #1;
        a = cyc;
        temp_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset_ready", temp_ready, 1);
        chk("post_reset_digits", {temp_value_100, temp_value_10, temp_value_1}, 0);
        chk("reset_cycle", cyc - a, 5);
        send(100, 3, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 999);
            send(v, $urandom_range(0, 6), 1'b0, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
